// File: rtl/demultiplexer1to8_tdm_if.sv
// ---------------------------------------------------------------------------
// demultiplexer1to8_tdm_if
// Bundles the serial TDM input and the deserialised frame outputs of
// demultiplexer1to8_tdm. Clock and reset are not part of the bundle.
//
//   in_bit    : serial data beat (one slot per accepted beat)
//   in_valid  : beat qualifier
//   sync      : frame marker, marks slot 0 on an accepted beat
//   err_clr   : clears the sticky error flag
//   out       : last completed frame, out[k] = slot-k bit
//   S         : current slot index (0..7, 8 = parity slot), 0 while hunting
//   out_valid : one-cycle pulse when out is updated
//   err       : sticky framing / parity error flag
//
// master : the producer of the serial stream (drives the inputs)
// slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface demultiplexer1to8_tdm_if;
    logic       in_bit;
    logic       in_valid;
    logic       sync;
    logic       err_clr;
    logic [7:0] out;
    logic [3:0] S;
    logic       out_valid;
    logic       err;

    modport master (
        output in_bit,
        output in_valid,
        output sync,
        output err_clr,
        input  out,
        input  S,
        input  out_valid,
        input  err
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        input  sync,
        input  err_clr,
        output out,
        output S,
        output out_valid,
        output err
    );
endinterface

// File: rtl/demultiplexer1to8_tdm.sv
// ---------------------------------------------------------------------------
// demultiplexer1to8_tdm
// Time-division demultiplexer: collects 8 serial beats, framed by a sync
// marker on slot 0, into an 8-bit word. Framing errors (missing or early
// sync) and, optionally, parity errors raise a sticky err flag. out only
// changes on a complete, error-free frame.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demultiplexer1to8_tdm_if.slave (in_bit, in_valid, sync, err_clr,
//           out, S, out_valid, err)
//
// Configuration:
//   DEMUX_TDM_PARITY_EN : when defined, each frame carries a 9th beat (S=8)
//                         holding even parity over the 8 data bits.
// ---------------------------------------------------------------------------
module demultiplexer1to8_tdm (
    input  logic                          clk,
    input  logic                          rst_n,
    demultiplexer1to8_tdm_if.slave        bus
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Even parity: the parity bit makes the XOR of data and parity zero.
    function automatic logic f_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

    state_t     r_state;
    logic [3:0] r_slot;
    logic [7:0] r_shadow;
    logic [7:0] r_out;
    logic       r_out_valid;
    logic       r_err;

    state_t     w_state_nxt;
    logic [3:0] w_slot_nxt;
    logic [7:0] w_shadow_nxt;
    logic [7:0] w_out_nxt;
    logic       w_out_valid_nxt;
    logic       w_err_nxt;
    logic       w_set_err;

    assign bus.out       = r_out;
    assign bus.S         = r_slot;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_slot      <= 4'd0;
            r_shadow    <= 8'h00;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot      <= w_slot_nxt;
            r_shadow    <= w_shadow_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state, slot sequencing, frame assembly and error detection.
    always_comb begin
        w_state_nxt     = r_state;
        w_slot_nxt      = r_slot;
        w_shadow_nxt    = r_shadow;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_set_err       = 1'b0;

        if (bus.in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (bus.sync) begin
                        w_shadow_nxt = {7'd0, bus.in_bit};
                        w_slot_nxt   = 4'd1;
                        w_state_nxt  = ST_RECV;
                    end else begin
                        w_state_nxt  = ST_HUNT;
                    end
                end
                ST_RECV: begin
                    if (bus.sync) begin
                        // Sync at S=0 is a clean back-to-back frame; anywhere
                        // else it is early and the partial frame is dropped.
                        if (r_slot != 4'd0) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_set_err = 1'b0;
                        end
                        w_shadow_nxt = {7'd0, bus.in_bit};
                        w_slot_nxt   = 4'd1;
                        w_state_nxt  = ST_RECV;
                    end else if (r_slot == 4'd0) begin
                        // Expected a frame start but got data: lose lock.
                        w_set_err   = 1'b1;
                        w_slot_nxt  = 4'd0;
                        w_state_nxt = ST_HUNT;
                    end else if (r_slot < 4'd7) begin
                        w_shadow_nxt[r_slot[2:0]] = bus.in_bit;
                        w_slot_nxt                = r_slot + 4'd1;
                    end
`ifdef DEMUX_TDM_PARITY_EN
                    else if (r_slot == 4'd7) begin
                        w_shadow_nxt[7] = bus.in_bit;
                        w_slot_nxt      = 4'd8;
                    end else if (r_slot == 4'd8) begin
                        if (f_parity_ok(r_shadow, bus.in_bit)) begin
                            w_out_nxt       = r_shadow;
                            w_out_valid_nxt = 1'b1;
                        end else begin
                            w_set_err       = 1'b1;
                        end
                        w_slot_nxt = 4'd0;
                    end
`else
                    else if (r_slot == 4'd7) begin
                        w_out_nxt       = {bus.in_bit, r_shadow[6:0]};
                        w_out_valid_nxt = 1'b1;
                        w_slot_nxt      = 4'd0;
                    end
`endif
                    else begin
                        // Unreachable slot value: recover by re-hunting.
                        w_set_err   = 1'b1;
                        w_slot_nxt  = 4'd0;
                        w_state_nxt = ST_HUNT;
                    end
                end
                default: begin
                    w_slot_nxt  = 4'd0;
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end else begin
            // Idle cycle: everything holds, no timeout.
            w_state_nxt = r_state;
        end

        // Sticky error; a new error wins over a simultaneous clear.
        if (w_set_err) begin
            w_err_nxt = 1'b1;
        end else if (bus.err_clr) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

endmodule

// File: tb/tb_demultiplexer1to8_tdm.sv
// ---------------------------------------------------------------------------
// tb_demultiplexer1to8_tdm
// Self-checking bench: directed frames plus randomized beats, compared every
// cycle against a queue-based frame model. Define DEMUX_TDM_PARITY_EN to
// exercise the parity build.
// ---------------------------------------------------------------------------
module tb_demultiplexer1to8_tdm;

`ifdef DEMUX_TDM_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic cmp_en   = 1'b0;

    demultiplexer1to8_tdm_if bus_if ();

    demultiplexer1to8_tdm u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         m_hunt;
    bit         m_q[$];
    logic [7:0] m_out;
    logic       m_vld;
    logic       m_err;

    task automatic model_reset();
        m_hunt = 1'b1;
        m_q.delete();
        m_out  = 8'h00;
        m_vld  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic s, input logic clr);
        bit         set_err;
        logic [7:0] d;
        bit         par;
        set_err = 1'b0;
        m_vld   = 1'b0;
        if (v) begin
            if (m_hunt) begin
                if (s) begin
                    m_hunt = 1'b0;
                    m_q    = {b};
                end
            end else if (m_q.size() == 0) begin
                if (s) m_q = {b};
                else begin
                    set_err = 1'b1;
                    m_hunt  = 1'b1;
                end
            end else if (s) begin
                set_err = 1'b1;
                m_q     = {b};
            end else begin
                m_q.push_back(b);
                if (m_q.size() == FRAME_LEN) begin
                    par = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        d[i] = m_q[i];
                        par  = par ^ m_q[i];
                    end
                    if (FRAME_LEN == 9 && par != m_q[FRAME_LEN-1]) begin
                        set_err = 1'b1;
                    end else begin
                        m_out = d;
                        m_vld = 1'b1;
                    end
                    m_q.delete();
                end
            end
        end
        if (set_err) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // Model advances on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(bus_if.in_valid, bus_if.in_bit, bus_if.sync, bus_if.err_clr);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out", bus_if.out, m_out);
            chk("cyc_S", {4'd0, bus_if.S}, (m_hunt ? 8'd0 : 8'(m_q.size())));
            chk("cyc_out_valid", {7'd0, bus_if.out_valid}, {7'd0, m_vld});
            chk("cyc_err", {7'd0, bus_if.err}, {7'd0, m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic b, input logic s);
        bus_if.in_valid = 1'b1;
        bus_if.in_bit   = b;
        bus_if.sync     = s;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.in_valid = 1'b0;
        repeat (n) begin
            bus_if.in_bit = 1'($urandom_range(0, 1));
            bus_if.sync   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus_if.sync = 1'b0;
    endtask

    task automatic clear_err();
        bus_if.err_clr = 1'b1;
        idle(1);
        bus_if.err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_wrong, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send(d[i], (i == 0));
            if (gaps && (i == 2 || i == 5)) begin
                idle($urandom_range(1, 3));
                chk("gap_S_hold", {4'd0, bus_if.S}, 8'(i + 1));
            end
        end
`ifdef DEMUX_TDM_PARITY_EN
        send((^d) ^ par_wrong, 1'b0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         pos;
        logic       acc;
        rst_n           = 1'b0;
        bus_if.in_bit   = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.sync     = 1'b0;
        bus_if.err_clr  = 1'b0;
        #3;
        chk("rst_out", bus_if.out, 8'h00);
        chk("rst_S", {4'd0, bus_if.S}, 8'h00);
        chk("rst_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
        chk("rst_err", {7'd0, bus_if.err}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Basic decode, LSB first.
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("a5_out", bus_if.out, 8'hA5);
        chk("a5_valid", {7'd0, bus_if.out_valid}, 8'h01);
        chk("a5_err", {7'd0, bus_if.err}, 8'h00);
        idle(1);
        chk("a5_valid_drop", {7'd0, bus_if.out_valid}, 8'h00);

        // Back-to-back frames with gaps inside.
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("3c_out", bus_if.out, 8'h3C);
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("c3_out", bus_if.out, 8'hC3);
        chk("c3_valid", {7'd0, bus_if.out_valid}, 8'h01);

        // Early sync at slot 4, then a full 0F frame.
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("early_pre_S", {4'd0, bus_if.S}, 8'd4);
        send_frame(8'h0F, 1'b0, 1'b0);
        chk("early_out", bus_if.out, 8'h0F);
        chk("early_err", {7'd0, bus_if.err}, 8'h01);

        // Missing sync, with a simultaneous clear: set must win.
        clear_err();
        chk("clr_err", {7'd0, bus_if.err}, 8'h00);
        bus_if.err_clr = 1'b1;
        send(1'b1, 1'b0);
        bus_if.err_clr = 1'b0;
        chk("miss_err_setwins", {7'd0, bus_if.err}, 8'h01);
        chk("miss_S", {4'd0, bus_if.S}, 8'h00);
        clear_err();
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        chk("hunt_ignore_err", {7'd0, bus_if.err}, 8'h00);
        chk("hunt_ignore_out", bus_if.out, 8'h0F);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("relock_out", bus_if.out, 8'h5A);

        // Reset mid-frame at slot 5.
        for (int i = 0; i < 5; i++) send(1'b1, (i == 0));
        chk("mid_S", {4'd0, bus_if.S}, 8'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", bus_if.out, 8'h00);
        chk("arst_S", {4'd0, bus_if.S}, 8'h00);
        chk("arst_err", {7'd0, bus_if.err}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("post_rst_S", {4'd0, bus_if.S}, 8'h00);
        send_frame(8'h96, 1'b0, 1'b0);
        chk("post_rst_out", bus_if.out, 8'h96);

`ifdef DEMUX_TDM_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b0);
        chk("par_bad_err", {7'd0, bus_if.err}, 8'h01);
        chk("par_bad_valid", {7'd0, bus_if.out_valid}, 8'h00);
        chk("par_bad_out", bus_if.out, 8'h96);
        clear_err();
        send_frame(8'h81, 1'b0, 1'b0);
        chk("par_ok_out", bus_if.out, 8'h81);
        chk("par_ok_valid", {7'd0, bus_if.out_valid}, 8'h01);
`endif

        // Randomized stream with occasional framing/parity faults.
        clear_err();
        pos = 0;
        acc = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bus_if.in_valid = ($urandom_range(0, 3) != 0);
            bus_if.err_clr  = ($urandom_range(0, 15) == 0);
            bus_if.in_bit   = 1'($urandom_range(0, 1));
            if (bus_if.in_valid) begin
                bus_if.sync = (pos == 0) ^ ($urandom_range(0, 24) == 0);
                if (pos == 8) bus_if.in_bit = acc ^ ($urandom_range(0, 5) == 0);
                if (pos == 0) acc = bus_if.in_bit;
                else if (pos < 8) acc = acc ^ bus_if.in_bit;
                pos = (pos + 1) % FRAME_LEN;
            end else begin
                bus_if.sync = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        bus_if.err_clr  = 1'b0;
        idle(3);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
